iommu_regif_arb: RTL and testbench
==================================

IOMMU_REGIF_ARB -- requirements
Module: iommu_regif_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: register address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: register data width in bits; STRB = DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum BUSY cycles without slave ready; legal range 1-255.
REQ-004 Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-005 Port: clk_i, in, 1, rising-edge clock.
REQ-006 Port: rst_ni, in, 1, asynchronous active-low reset.
REQ-007 Ports: rq{0,1}_valid_i, in, 1, requester n access request; held until ready.
REQ-008 Ports: rq{0,1}_write_i, in, 1, 1 = write, 0 = read.
REQ-009 Ports: rq{0,1}_addr_i, in, ADDR_WIDTH, access address.
REQ-010 Ports: rq{0,1}_wdata_i, in, DATA_WIDTH, write data.
REQ-011 Ports: rq{0,1}_wstrb_i, in, STRB, byte enables.
REQ-012 Ports: rq{0,1}_ready_o, out, 1, single-cycle completion pulse.
REQ-013 Ports: rq{0,1}_rdata_o, out, DATA_WIDTH, read data, valid with ready.
REQ-014 Ports: rq{0,1}_error_o, out, 1, error, valid with ready.
REQ-015 Ports: reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o, out, widths as above; request to the IOMMU register map.
REQ-016 Ports: reg_ready_i (1), reg_rdata_i (DATA_WIDTH), reg_error_i (1), in; register map response.
REQ-017 Port: timeout_o, out, 1, one-cycle pulse on each timeout abort.

Function
REQ-018 FSM states: IDLE, BUSY, TOERR; owner register (1 bit); round-robin priority pointer prio (1 bit); timeout counter cnt (8 bits).
REQ-019 IDLE: if exactly one rqN_valid_i is high, owner = N; if both are high, owner = prio; move to BUSY next cycle; no response is given in IDLE.
REQ-020 BUSY: reg_valid_o = 1; reg_write/addr/wdata/wstrb are driven combinationally from the owner's inputs.
REQ-021 BUSY with reg_ready_i = 1: same-cycle owner ready_o = 1, rdata_o = reg_rdata_i, error_o = reg_error_i; next state IDLE; prio = ~owner.
REQ-022 Minimum latency from valid to ready is 2 cycles: arbitration cycle plus one BUSY cycle.
REQ-023 cnt clears on IDLE->BUSY and increments each BUSY cycle without reg_ready_i; when cnt == TIMEOUT_CYCLES-1 with no ready, next state is TOERR.
REQ-024 TOERR lasts one cycle: reg_valid_o = 0; owner ready_o = 1, error_o = 1, rdata_o = 0; timeout_o = 1; prio = ~owner; next state IDLE.
REQ-025 If the owner deasserts valid in BUSY (protocol violation), reg_valid_o drops in the same cycle; next state IDLE; no response; prio unchanged.
REQ-026 The non-owner sees ready_o = 0, rdata_o = 0, error_o = 0 at all times; its request waits.
REQ-027 Outside BUSY: all reg_*_o = 0; all rqN_ready_o, rdata_o, error_o = 0 except as stated in REQ-024.
REQ-028 reg_ready_i outside BUSY is ignored.
REQ-029 Back-to-back requests: after completion, one IDLE cycle precedes the next grant.

Reset
REQ-030 Asynchronous assertion forces state IDLE, owner 0, prio 0, cnt 0; all outputs 0 while reset is low.
REQ-031 Reset in BUSY or TOERR drops the transaction with no response; after deassertion the first grant follows REQ-019 with prio = 0.

Verification
REQ-032 rq0 read addr 0x10, slave ready on the 1st BUSY cycle with rdata 0xDEADBEEF -> rq0_ready_o pulses at cycle 2 with rdata 0xDEADBEEF, error_o 0; reg_valid_o high exactly one cycle.
REQ-033 rq0 and rq1 valid in the same cycle after reset -> rq0 served first, then rq1; repeat with both still valid -> rq0 then rq1 alternately.
REQ-034 TIMEOUT_CYCLES = 4, slave never ready -> reg_valid_o high 4 cycles, then TOERR: ready_o = 1, error_o = 1, rdata_o = 0, timeout_o = 1, then IDLE.
REQ-035 rq1 write wstrb 0x3 with reg_error_i = 1 on ready -> rq1 error_o = 1, write fields match rq1 inputs on reg_*_o.
REQ-036 rst_ni low during BUSY -> all outputs 0 immediately; after release, a pending rq1 request is granted normally.
REQ-037 Owner drops valid in BUSY -> reg_valid_o = 0 in the same cycle, no ready pulse, next request arbitrates with prio unchanged.

Source files
------------

// File: rtl/iommu_regif_arb.sv
// Two-requester round-robin arbiter in front of the IOMMU register map.
// One access is in flight at a time, and a slave timeout aborts it with an error response.
module iommu_regif_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rq0_valid_i,
  input  logic                    rq0_write_i,
  input  logic [ADDR_WIDTH-1:0]   rq0_addr_i,
  input  logic [DATA_WIDTH-1:0]   rq0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] rq0_wstrb_i,
  output logic                    rq0_ready_o,
  output logic [DATA_WIDTH-1:0]   rq0_rdata_o,
  output logic                    rq0_error_o,
  input  logic                    rq1_valid_i,
  input  logic                    rq1_write_i,
  input  logic [ADDR_WIDTH-1:0]   rq1_addr_i,
  input  logic [DATA_WIDTH-1:0]   rq1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] rq1_wstrb_i,
  output logic                    rq1_ready_o,
  output logic [DATA_WIDTH-1:0]   rq1_rdata_o,
  output logic                    rq1_error_o,
  output logic                    reg_valid_o,
  output logic                    reg_write_o,
  output logic [ADDR_WIDTH-1:0]   reg_addr_o,
  output logic [DATA_WIDTH-1:0]   reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
  input  logic                    reg_ready_i,
  input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
  input  logic                    reg_error_i,
  output logic                    timeout_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    TOERR = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic                    owner_r, owner_nxt_s;
  logic                    prio_r, prio_nxt_s;
  logic [7:0]              cnt_r, cnt_nxt_s;
  logic                    own_valid_s;
  logic                    rsp_s;
  logic                    rsp_err_s;
  logic [DATA_WIDTH-1:0]   rsp_data_s;

  // State, owner, priority pointer and timeout counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      prio_r  <= prio_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic, register-map request and requester responses
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    prio_nxt_s  = prio_r;
    cnt_nxt_s   = cnt_r;
    own_valid_s = owner_r ? rq1_valid_i : rq0_valid_i;
    rsp_s       = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = '0;
    timeout_o   = 1'b0;
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    reg_wstrb_o = '0;

    case (state_r)
      IDLE: begin
        if (rq0_valid_i || rq1_valid_i) begin
          owner_nxt_s = (rq0_valid_i && rq1_valid_i) ? prio_r : rq1_valid_i;
          cnt_nxt_s   = 8'd0;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // A withdrawn request is abandoned silently and does not move the priority pointer
        if (!own_valid_s) begin
          state_nxt_s = IDLE;
        end else begin
          reg_valid_o = 1'b1;
          reg_write_o = owner_r ? rq1_write_i : rq0_write_i;
          reg_addr_o  = owner_r ? rq1_addr_i  : rq0_addr_i;
          reg_wdata_o = owner_r ? rq1_wdata_i : rq0_wdata_i;
          reg_wstrb_o = owner_r ? rq1_wstrb_i : rq0_wstrb_i;
          if (reg_ready_i) begin
            rsp_s       = 1'b1;
            rsp_err_s   = reg_error_i;
            rsp_data_s  = reg_rdata_i;
            prio_nxt_s  = ~owner_r;
            state_nxt_s = IDLE;
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = TOERR;
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end
      end
      TOERR: begin
        rsp_s       = 1'b1;
        rsp_err_s   = 1'b1;
        timeout_o   = 1'b1;
        prio_nxt_s  = ~owner_r;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    rq0_ready_o = rsp_s & ~owner_r;
    rq0_error_o = rsp_err_s & ~owner_r;
    rq0_rdata_o = (rsp_s && !owner_r) ? rsp_data_s : '0;
    rq1_ready_o = rsp_s & owner_r;
    rq1_error_o = rsp_err_s & owner_r;
    rq1_rdata_o = (rsp_s && owner_r) ? rsp_data_s : '0;
  end

endmodule

// File: tb/tb_iommu_regif_arb.sv
// Directed table-driven bench for iommu_regif_arb (TIMEOUT_CYCLES = 4).
// Each table row is one clock cycle of stimulus plus the outputs expected during that cycle.
module tb_iommu_regif_arb;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        rq0_valid, rq1_valid;
  logic        rq0_ready, rq1_ready, rq0_error, rq1_error;
  logic [31:0] rq0_rdata, rq1_rdata;
  logic        reg_valid, reg_write, reg_ready, reg_error, timeout;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;

  localparam logic [31:0] A0 = 32'h0000_0010, D0 = 32'h1111_1111;
  localparam logic [31:0] A1 = 32'h0000_0020, D1 = 32'hCAFE_F00D;
  localparam logic [3:0]  S0 = 4'hF, S1 = 4'h3;

  always #5 clk = ~clk;

  iommu_regif_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rq0_valid_i(rq0_valid), .rq0_write_i(1'b0), .rq0_addr_i(A0), .rq0_wdata_i(D0), .rq0_wstrb_i(S0),
    .rq0_ready_o(rq0_ready), .rq0_rdata_o(rq0_rdata), .rq0_error_o(rq0_error),
    .rq1_valid_i(rq1_valid), .rq1_write_i(1'b1), .rq1_addr_i(A1), .rq1_wdata_i(D1), .rq1_wstrb_i(S1),
    .rq1_ready_o(rq1_ready), .rq1_rdata_o(rq1_rdata), .rq1_error_o(rq1_error),
    .reg_valid_o(reg_valid), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
    .reg_ready_i(reg_ready), .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
    .timeout_o(timeout)
  );

  typedef struct {
    logic v0, v1, rdy, rerr;
    logic [31:0] rdata;
    logic e_rv, e_own, e_rsp, e_err;
    logic [31:0] e_rd;
    logic e_to;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[24];

  function automatic vec_t mk(logic v0, logic v1, logic rdy, logic rerr, logic [31:0] rdata,
                              logic e_rv, logic e_own, logic e_rsp, logic e_err,
                              logic [31:0] e_rd, logic e_to);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.rerr = rerr; v.rdata = rdata;
    v.e_rv = e_rv; v.e_own = e_own; v.e_rsp = e_rsp; v.e_err = e_err; v.e_rd = e_rd; v.e_to = e_to;
    return v;
  endfunction

  // Expected full output word: response goes only to the owner; reg bus carries the owner's fields
  function automatic logic [138:0] expect_of(vec_t v);
    logic r0, r1;
    r0 = v.e_rsp & ~v.e_own;
    r1 = v.e_rsp & v.e_own;
    return {r0, (r0 ? v.e_rd : 32'h0), r0 & v.e_err,
            r1, (r1 ? v.e_rd : 32'h0), r1 & v.e_err,
            v.e_rv, v.e_rv & v.e_own,
            (v.e_rv ? (v.e_own ? A1 : A0) : 32'h0),
            (v.e_rv ? (v.e_own ? D1 : D0) : 32'h0),
            (v.e_rv ? (v.e_own ? S1 : S0) : 4'h0),
            v.e_to};
  endfunction

  function automatic logic [138:0] actual();
    return {rq0_ready, rq0_rdata, rq0_error, rq1_ready, rq1_rdata, rq1_error,
            reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb, timeout};
  endfunction

  task automatic check(string name, vec_t v);
    logic [138:0] exp_w, act_w;
    exp_w = expect_of(v);
    act_w = actual();
    total_cnt++;
    if (act_w !== exp_w) begin
      $display("FAIL %s: got %h expected %h", name, act_w, exp_w);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic drive(vec_t v);
    rq0_valid = v.v0; rq1_valid = v.v1;
    reg_ready = v.rdy; reg_error = v.rerr; reg_rdata = v.rdata;
  endtask

  initial begin
    vec_t z;
    z = mk(0,0,0,0,32'h0, 0,0,0,0,32'h0,0);

    //             v0 v1 rdy rerr rdata         rv own rsp err e_rd          to
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[1]  = mk(1, 1, 1, 0, 32'hA1A1_A1A1,  1, 0, 1, 0, 32'hA1A1_A1A1,  0);
    vecs[2]  = mk(1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[3]  = mk(1, 1, 1, 0, 32'hB2B2_B2B2,  1, 1, 1, 0, 32'hB2B2_B2B2,  0);
    vecs[4]  = mk(1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[5]  = mk(1, 1, 1, 0, 32'hC3C3_C3C3,  1, 0, 1, 0, 32'hC3C3_C3C3,  0);
    vecs[6]  = mk(1, 0, 1, 0, 32'h5555_5555,  0, 0, 0, 0, 32'h0,          0);
    vecs[7]  = mk(1, 0, 1, 0, 32'hDEAD_BEEF,  1, 0, 1, 0, 32'hDEAD_BEEF,  0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[9]  = mk(0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[10] = mk(0, 1, 1, 1, 32'h1234_5678,  1, 1, 1, 1, 32'h1234_5678,  0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[12] = mk(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    for (int i = 13; i < 17; i++)
      vecs[i] = mk(1, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0,          0);
    vecs[17] = mk(1, 0, 1, 0, 32'hFFFF_FFFF,  0, 0, 1, 1, 32'h0,          1);
    vecs[18] = mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[19] = mk(1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[20] = mk(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[21] = mk(1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[22] = mk(1, 1, 1, 0, 32'h7777_7777,  1, 1, 1, 0, 32'h7777_7777,  0);
    vecs[23] = mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0);

    // Reset held with traffic present: everything must stay quiet
    rst_ni = 1'b0;
    drive(mk(1,1,1,1,32'hFFFF_FFFF, 0,0,0,0,32'h0,0));
    @(negedge clk);
    check("reset_quiet", z);
    drive(z);
    rst_ni = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted mid-BUSY, then a waiting rq1 is granted normally
    @(posedge clk); #1;
    drive(mk(1,1,0,0,32'h0, 0,0,0,0,32'h0,0));
    @(negedge clk);
    check("rst_arb", z);
    @(posedge clk); #1;
    check("rst_busy_pre", mk(0,0,0,0,32'h0, 1,0,0,0,32'h0,0));
    rst_ni = 1'b0; #1;
    check("rst_busy_drop", z);
    drive(mk(0,1,0,0,32'h0, 0,0,0,0,32'h0,0));
    @(negedge clk);
    rst_ni = 1'b1; #1;
    check("rst_released", z);
    @(posedge clk); #1;
    drive(mk(0,1,1,0,32'h0000_0099, 0,0,0,0,32'h0,0));
    @(negedge clk);
    check("rst_rq1_grant", mk(0,0,0,0,32'h0, 1,1,1,0,32'h0000_0099,0));
    @(posedge clk); #1;
    drive(z);
    @(negedge clk);
    check("rst_rq1_done", z);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
